// File: rtl/um245r_tx_ctrl.sv
// um245r_tx_ctrl: queues CPU {A,B} bytes captured on TX rising edges and
// writes them to a UM245R (FT245-style) via setup / WR pulse / recovery,
// gated by the synchronized TXE# handshake.
// Optional build macro UM245R_TIMEOUT_EN: flush the queue when TXE# keeps
// the device blocked for TIMEOUT idle cycles, and raise a sticky timeout flag.
module um245r_tx_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned RECOVER  = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                     csc_clk,
    input  logic                     Reset,
    input  logic                     TX,
    input  logic [7:0]               AB,
    input  logic                     txe_n,
    output logic                     wr,
    output logic [7:0]               d_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     full,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CMAX = (WR_PULSE > RECOVER) ? WR_PULSE : RECOVER;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOV} state_t;

    // Reject parameter sets the pointer and counter logic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WR_PULSE < 1 || RECOVER < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("um245r_tx_ctrl: illegal parameter set");
    end

    logic          tx_armed;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          flush;
    logic          load_d;
    logic          txe_m;
    logic          txe_s;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    // tx_armed records "TX was low last cycle"; clearing it in reset means a
    // TX already high at release is not taken as a rising edge.
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) tx_armed <= 1'b0;
        else       tx_armed <= ~TX;
    end

    assign push    = TX & tx_armed;
    assign full    = (fifo_count == (AW+1)'(DEPTH));
    assign push_ok = push & (flush | ~full | pop);

    // Two-flop synchronizer for TXE#, preset to "not ready".
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) begin
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            txe_m <= txe_n;
            txe_s <= txe_m;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge csc_clk) begin
        if (push_ok) mem[tail] <= AB;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            head       <= tail;
            tail       <= push ? tail + AW'(1) : tail;
            fifo_count <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push_ok) tail <= tail + AW'(1);
            if (pop)     head <= head + AW'(1);
            if (push & ~push_ok) overflow <= 1'b1;
            unique case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Write sequencer state and phase counter register.
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Write sequencer next-state: idle/setup/WR pulse/recovery.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load_d  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0 && !txe_s) begin
                    load_d  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = PULSE;
                cnt_n   = CW'(WR_PULSE - 1);
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = RECOV;
                    pop     = 1'b1;
                    cnt_n   = CW'(RECOVER - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RECOV: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Output registers: WR follows the next state so it is glitch-free,
    // d_out is loaded only when a write is committed.
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) begin
            wr    <= 1'b0;
            d_out <= '0;
        end else begin
            wr <= (state_n == PULSE);
            if (load_d) d_out <= mem[head];
        end
    end

`ifdef UM245R_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic          blocked;
    logic [TW-1:0] tcnt;
    logic          timeout_r;

    assign blocked = (state == IDLE) && (fifo_count != '0) && txe_s;
    assign flush   = blocked && (tcnt == TW'(TIMEOUT - 1));
    assign timeout = timeout_r;

    // Count consecutive blocked idle cycles; flush on reaching TIMEOUT.
    always_ff @(posedge csc_clk or posedge Reset) begin
        if (Reset) begin
            tcnt      <= '0;
            timeout_r <= 1'b0;
        end else if (!blocked || flush) begin
            tcnt <= '0;
            if (flush) timeout_r <= 1'b1;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end
`else
    assign flush   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_um245r_tx_ctrl.sv
// tb_um245r_tx_ctrl: directed scenarios plus randomized traffic, checked
// against a queue-based reference of the byte path and WR protocol rules.
module tb_um245r_tx_ctrl;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WR_PULSE = 2;
    localparam int unsigned RECOVER  = 2;
`ifdef UM245R_TIMEOUT_EN
    localparam int unsigned TIMEOUT  = 16;
`else
    localparam int unsigned TIMEOUT  = 255;
`endif

    logic       csc_clk = 1'b0;
    logic       Reset   = 1'b1;
    logic       TX      = 1'b0;
    logic [7:0] AB      = 8'h00;
    logic       txe_n   = 1'b1;
    logic       wr;
    logic [7:0] d_out;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       full;
    logic       overflow;
    logic       timeout;

    um245r_tx_ctrl #(
        .DEPTH(DEPTH),
        .WR_PULSE(WR_PULSE),
        .RECOVER(RECOVER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .csc_clk(csc_clk),
        .Reset(Reset),
        .TX(TX),
        .AB(AB),
        .txe_n(txe_n),
        .wr(wr),
        .d_out(d_out),
        .fifo_count(fifo_count),
        .full(full),
        .overflow(overflow),
        .timeout(timeout)
    );

    always #5 csc_clk = ~csc_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference state
    int         cyc = 0;
    logic [7:0] q[$];
    bit         ovf_m = 0;
    bit         to_m = 0;
    bit         armed_m = 0;
    bit         wr_prev = 0;
    logic [7:0] dprev = 8'h00;
    int         hi_cnt = 0;
    int         last_rise = -100;
    int         rise_q[$];
    int         rise_total = 0;
    logic [7:0] last_sent = 8'h00;
    bit         txh [4096];
    int         flush_at = -1;

    // Per-edge reference update and protocol checks, sampled 1 ns after the edge.
    always @(posedge csc_clk) begin
        logic       tx_s;
        logic [7:0] ab_s;
        logic       rst_s;
        logic       push_m;
        logic       rise;
        logic       fall;
        logic [7:0] exp_b;
        cyc++;
        tx_s  = TX;
        ab_s  = AB;
        rst_s = Reset;
        txh[cyc % 4096] = txe_n;
        #1;
        if (rst_s) begin
            q.delete();
            ovf_m = 0; to_m = 0; armed_m = 0; wr_prev = 0; hi_cnt = 0; dprev = 8'h00;
            check_eq("rst_wr", wr, 0);
            check_eq("rst_dout", d_out, 0);
            check_eq("rst_count", fifo_count, 0);
            check_eq("rst_ovf", overflow, 0);
            check_eq("rst_timeout", timeout, 0);
        end else begin
            push_m  = tx_s && armed_m;
            armed_m = !tx_s;
            rise = wr && !wr_prev;
            fall = !wr && wr_prev;
            if (wr) hi_cnt++;
            if (rise) begin
                check_eq("txe_gate", txh[(cyc + 4093) % 4096], 0);
                check_eq("setup_dout", d_out, dprev);
                check_eq("byte_period_ok", (cyc - last_rise) >= 6, 1);
                if (q.size() > 0) check_eq("dout_head", d_out, q[0]);
                else              check_eq("write_from_empty", q.size(), 1);
                last_rise = cyc;
                rise_q.push_back(cyc);
                rise_total++;
            end
            if (wr && wr_prev) check_eq("dout_stable", d_out, dprev);
            if (fall) begin
                check_eq("wr_width", hi_cnt, WR_PULSE);
                hi_cnt = 0;
                if (q.size() > 0) begin
                    exp_b = q.pop_front();
                    check_eq("sent_byte", d_out, exp_b);
                    last_sent = exp_b;
                end else begin
                    check_eq("pop_empty", q.size(), 1);
                end
            end
            if (cyc == flush_at) begin
                q.delete();
                to_m = 1;
            end
            if (push_m) begin
                if (q.size() == DEPTH) ovf_m = 1;
                else                   q.push_back(ab_s);
            end
            check_eq("fifo_count", fifo_count, q.size());
            check_eq("full", full, q.size() == DEPTH);
            check_eq("overflow", overflow, ovf_m);
            check_eq("timeout", timeout, to_m);
            wr_prev = wr;
            dprev   = d_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge csc_clk);
    endtask

    task automatic pulse_tx(input logic [7:0] b);
        @(negedge csc_clk);
        AB = b;
        TX = 1'b1;
        @(negedge csc_clk);
        TX = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge csc_clk);
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    task automatic wait_rise(input string tag, input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge csc_clk);
            #2;
            if (wr) begin
                ok = 1;
                break;
            end
        end
        check_eq(tag, ok, 1);
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge csc_clk);
            #2;
            if (q.size() == 0 && !wr) begin
                ok = 1;
                break;
            end
        end
        check_eq(tag, ok, 1);
        tick(RECOVER + 2);
    endtask

    initial begin
        int hi_run;
        tick(3);
        Reset = 1'b0;

        // 1: single byte, exact latency
        txe_n = 1'b0;
        tick(4);
        @(negedge csc_clk);
        AB = 8'hA5;
        TX = 1'b1;
        @(posedge csc_clk); #2;
        check_eq("t1_e0_count", fifo_count, 1);
        check_eq("t1_e0_wr", wr, 0);
        @(negedge csc_clk);
        TX = 1'b0;
        @(posedge csc_clk); #2;
        check_eq("t1_e1_dout", d_out, 8'hA5);
        check_eq("t1_e1_wr", wr, 0);
        @(posedge csc_clk); #2;
        check_eq("t1_e2_wr", wr, 1);
        @(posedge csc_clk); #2;
        check_eq("t1_e3_wr", wr, 1);
        check_eq("t1_e3_count", fifo_count, 1);
        @(posedge csc_clk); #2;
        check_eq("t1_e4_wr", wr, 0);
        check_eq("t1_e4_count", fifo_count, 0);
        check_eq("t1_ovf", overflow, 0);
        tick(4);

        // 2: overflow while blocked, then in-order drain at minimum period
        txe_n = 1'b1;
        tick(3);
        for (int b = 1; b <= 5; b++) pulse_tx(8'(b));
        check_eq("t2_count", fifo_count, 4);
        check_eq("t2_full", full, 1);
        check_eq("t2_ovf", overflow, 1);
        rise_q.delete();
        txe_n = 1'b0;
        wait_drain("t2_drain", 100);
        check_eq("t2_writes", rise_q.size(), 4);
        for (int i = 1; i < rise_q.size(); i++) check_eq("t2_period", rise_q[i] - rise_q[i-1], 6);
        check_eq("t2_last", last_sent, 8'h04);

        // 3: push coincident with pop while full
        do_reset();
        txe_n = 1'b1;
        tick(3);
        for (int b = 0; b < 4; b++) pulse_tx(8'(8'h10 + b));
        check_eq("t3_full", full, 1);
        txe_n = 1'b0;
        wait_rise("t3_rise", 20);
        repeat (WR_PULSE) @(negedge csc_clk);
        AB = 8'h14;
        TX = 1'b1;
        @(posedge csc_clk); #2;
        check_eq("t3_fall_wr", wr, 0);
        check_eq("t3_count", fifo_count, 4);
        check_eq("t3_ovf", overflow, 0);
        @(negedge csc_clk);
        TX = 1'b0;
        wait_drain("t3_drain", 100);
        check_eq("t3_last", last_sent, 8'h14);

        // 4: TXE# high during the pulse delays only the next byte
        txe_n = 1'b1;
        tick(3);
        pulse_tx(8'h21);
        pulse_tx(8'h22);
        rise_q.delete();
        txe_n = 1'b0;
        wait_rise("t4_rise", 20);
        @(negedge csc_clk);
        txe_n = 1'b1;
        tick(6);
        txe_n = 1'b0;
        wait_drain("t4_drain", 60);
        check_eq("t4_writes", rise_q.size(), 2);
        if (rise_q.size() == 2) check_eq("t4_gap", rise_q[1] - rise_q[0], 10);

        // 5: reset mid-pulse, TX held high across release
        pulse_tx(8'h31);
        pulse_tx(8'h32);
        wait_rise("t5_rise", 20);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("t5_async_wr", wr, 0);
        check_eq("t5_async_count", fifo_count, 0);
        TX = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(3);
        check_eq("t5_no_push", fifo_count, 0);
        TX = 1'b0;
        tick(2);
        check_eq("t5_after_low", fifo_count, 0);

        // Randomized traffic; TXE# high runs kept short
        hi_run = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge csc_clk);
            TX = 1'($urandom_range(0, 1));
            AB = 8'($urandom);
            if (txe_n) begin
                hi_run++;
                if (hi_run >= 4 || $urandom_range(0, 2) == 0) txe_n = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                txe_n  = 1'b1;
                hi_run = 0;
            end
        end
        @(negedge csc_clk);
        TX = 1'b0;
        txe_n = 1'b0;
        wait_drain("rand_drain", 200);

`ifdef UM245R_TIMEOUT_EN
        // 6: blocked queue is flushed after TIMEOUT idle cycles
        begin
            int r0;
            do_reset();
            txe_n = 1'b1;
            tick(3);
            r0 = rise_total;
            @(negedge csc_clk);
            AB = 8'h61;
            TX = 1'b1;
            flush_at = cyc + 1 + TIMEOUT;
            @(negedge csc_clk);
            TX = 1'b0;
            pulse_tx(8'h62);
            while (cyc < flush_at - 1) @(negedge csc_clk);
            check_eq("t6_pre_count", fifo_count, 2);
            check_eq("t6_pre_timeout", timeout, 0);
            while (cyc < flush_at) @(negedge csc_clk);
            check_eq("t6_count", fifo_count, 0);
            check_eq("t6_timeout", timeout, 1);
            tick(5);
            check_eq("t6_no_write", rise_total, r0);
            check_eq("t6_sticky", timeout, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
